icache_l1_ctrl: RTL and testbench
=================================

Name: icache_l1_ctrl

Overview:
- Control FSM for the direct-mapped L1 instruction cache: 32 sets, 256-bit (32-byte) lines.
- Sequences two external 32-entry asynchronous-read line arrays: the data array (256 bits wide) and the tag array (TAG_W bits wide).
- Holds the valid bits internally.
- Sits between the IF stage (CPU side) and the L2/arbiter physical-memory port.
- Serves hits in zero wait cycles and handles misses with a single-burst line fill.

Parameters:
- LINE_W, 256, cache line width in bits.
- TAG_W, 22, tag width; equals address bits [31:10].
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU fetch request; held high until mem_resp
- mem_address  in  32  CPU byte address; word-aligned
- mem_rdata  out  32  fetched instruction word
- mem_resp  out  1  one-cycle completion pulse
- flush  in  1  invalidate all lines (fence.i)
- pmem_read  out  1  line-fill request; held high until pmem_resp
- pmem_address  out  32  line-aligned fill address
- pmem_rdata  in  LINE_W  fill data; valid when pmem_resp is high
- pmem_resp  in  1  fill completion pulse
- arr_index  out  5  set index to both arrays
- arr_write  out  1  write strobe to both arrays
- data_in  out  LINE_W  data array write data
- data_out  in  LINE_W  data array asynchronous read data
- tag_in  out  TAG_W  tag array write data
- tag_out  in  TAG_W  tag array asynchronous read data
- hit_count  out  CNT_W  number of hits served
- miss_count  out  CNT_W  number of misses taken

Behaviour:
- Address split: offset = [4:0], word = [4:2], index = [9:5], tag = [31:10].
- hit = mem_read & valid[index] & (tag_out == mem_address[31:10]).
- FSM states:
  - CHECK (reset state): arr_index = mem_address[9:5].
    - On hit: mem_resp = 1 in the same cycle, and mem_rdata = data_out[32*word +: 32]. Zero wait cycles.
    - On miss (mem_read & !hit): latch the tag and index into miss_tag and miss_idx, then go to FETCH.
  - FETCH: pmem_read = 1 and pmem_address = {miss_tag, miss_idx, 5'b0}.
    - On pmem_resp: capture pmem_rdata into fill_buf, then go to FILL.
  - FILL: arr_index = miss_idx and arr_write = 1 for exactly one cycle.
    - data_in = fill_buf, tag_in = miss_tag, valid[miss_idx] <= 1. Go to CHECK.
- Miss latency: the request is answered in CHECK on the first cycle after FILL. That is one cycle after FILL, and two cycles after pmem_resp.
- mem_resp is never asserted in FETCH or FILL. pmem_read is never asserted outside FETCH.
- Combinational outputs: mem_resp, mem_rdata, pmem_read, pmem_address, arr_index, arr_write, data_in and tag_in are combinational from the state and registers.
- Off-state values: mem_rdata = 0 when mem_resp = 0. pmem_address = 0 outside FETCH. data_in and tag_in = 0 outside FILL.
- Reset:
  - Clears state to CHECK, all 32 valid bits, miss_tag, miss_idx, fill_buf, hit_count and miss_count.
  - Outputs then follow the CHECK rules: pmem_read = 0 and arr_write = 0.
  - Reset mid-FETCH drops pmem_read the next cycle; the pending fill is abandoned.
- Request change during a miss: if mem_read drops or mem_address changes during FETCH or FILL, the fill still completes using the latched miss_tag and miss_idx. CHECK then re-evaluates the current request.
- flush:
  - Clears all valid bits on the clock edge in any state. It does not change the FSM state.
  - flush in CHECK: the same-cycle hit is still served; the valid bits clear at the edge.
  - flush in FILL: the flush wins, so valid[miss_idx] ends at 0. The CHECK that follows misses and refetches.
- Counters:
  - hit_count increments on each cycle with mem_resp in CHECK where the hit was not a post-fill re-check.
  - miss_count increments on each CHECK->FETCH transition.
  - A post-fill response counts as a miss only.
  - Both counters wrap modulo 2^CNT_W.
- Aliasing: the same index with a different tag is a conflict miss, and the fill overwrites the old line.

Decomposition:
- Package icache_pkg:
  - State enum: CHECK, FETCH, FILL.
  - Constants: OFFSET_W = 5, INDEX_W = 5, TAG_W = 22.
  - Address field-extraction functions.
- Sub-module icache_l1_valid holds the 32-bit valid vector.
  - Inputs: rst, flush, set (with set index).
  - Output: valid[index], as an asynchronous read.
  - Priority: rst, then flush, then set.
- The arrays themselves are instantiated by the cache top, not inside this block.

Test Plan:
- Cold miss:
  - Stimulus: after reset, mem_read with addr 0x0000_0124; pmem_resp after 3 cycles with line word1 = 0xDEADBEEF.
  - Required: pmem_address = 0x0000_0120; one arr_write to index 9; mem_resp two cycles after pmem_resp with mem_rdata = 0xDEADBEEF; miss_count = 1.
- Hit:
  - Stimulus: repeat addr 0x0000_0124.
  - Required: mem_resp in the same cycle; pmem_read stays 0; hit_count = 1.
- Conflict:
  - Stimulus: read 0x0000_0524 (same index 9, tag 1).
  - Required: miss and refill of index 9; a subsequent read of 0x0000_0124 misses again.
- Flush:
  - Stimulus: fill index 9, pulse flush, read 0x0000_0124.
  - Required: miss; pmem_read asserted.
- Flush during FILL:
  - Required: valid[9] = 0; the post-FILL CHECK issues a new FETCH.
- Reset mid-FETCH and request change:
  - Stimulus: raise rst while in FETCH.
  - Required: next cycle pmem_read = 0, state CHECK, counters 0.
  - Stimulus: separately, change mem_address during FETCH.
  - Required: the fill targets the latched index.

Source files
------------

// File: rtl/icache_l1_ctrl_pkg.sv
// Shared types, widths and address-field helpers for the L1 instruction cache.
package icache_pkg;

    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned INDEX_W  = 5;
    localparam int unsigned TAG_W    = 22;
    localparam int unsigned NUM_SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {
        CHECK,
        FETCH,
        FILL
    } state_t;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [2:0] addr_word(input logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31 -: TAG_W];
    endfunction

endpackage

// File: rtl/icache_l1_ctrl_if.sv
// CPU fetch port and physical-memory fill port of the L1 instruction cache.
interface icache_cpu_if;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (output mem_read, mem_address, input mem_rdata, mem_resp);
    modport slave  (input mem_read, mem_address, output mem_rdata, mem_resp);
endinterface

interface icache_pmem_if #(
    parameter int unsigned LINE_W = 256
);
    logic              pmem_read;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (output pmem_read, pmem_address, input pmem_rdata, pmem_resp);
    modport slave  (input pmem_read, pmem_address, output pmem_rdata, pmem_resp);
endinterface

// File: rtl/icache_l1_valid.sv
// Per-set valid bits with asynchronous read; reset beats flush beats set.
module icache_l1_valid
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               set,
    input  logic [INDEX_W-1:0] set_idx,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               valid
);

    logic [NUM_SETS-1:0] bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            bits <= '0;
        end else if (flush) begin
            bits <= '0;
        end else if (set) begin
            bits[set_idx] <= 1'b1;
        end
    end

    assign valid = bits[rd_idx];

endmodule

// File: rtl/icache_l1_ctrl.sv
// Direct-mapped L1 I-cache controller: zero-wait hits, single-burst line fill on miss.
module icache_l1_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned TAG_W  = 22,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    icache_cpu_if.slave         cpu,
    icache_pmem_if.master       pmem,
    input  logic                flush,
    output logic [INDEX_W-1:0]  arr_index,
    output logic                arr_write,
    output logic [LINE_W-1:0]   data_in,
    input  logic [LINE_W-1:0]   data_out,
    output logic [TAG_W-1:0]    tag_in,
    input  logic [TAG_W-1:0]    tag_out,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    state_t              state, state_n;
    logic [TAG_W-1:0]    miss_tag;
    logic [INDEX_W-1:0]  miss_idx;
    logic [LINE_W-1:0]   fill_buf;
    logic                post_fill;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [2:0]          req_word;
    logic                valid_rd;
    logic                hit;

    logic                resp;
    logic [31:0]         rdata;
    logic                p_read;
    logic [31:0]         p_addr;
    logic                set_valid;
    logic                unused_addr_bits;

    assign req_tag  = cpu.mem_address[31 -: TAG_W];
    assign req_idx  = addr_index(cpu.mem_address);
    assign req_word = addr_word(cpu.mem_address);
    assign unused_addr_bits = ^cpu.mem_address[1:0];

    icache_l1_valid u_valid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .set     (set_valid),
        .set_idx (miss_idx),
        .rd_idx  (req_idx),
        .valid   (valid_rd)
    );

    assign hit = cpu.mem_read & valid_rd & (tag_out == req_tag);

    always_comb begin
        state_n   = state;
        resp      = 1'b0;
        rdata     = '0;
        p_read    = 1'b0;
        p_addr    = '0;
        arr_index = req_idx;
        arr_write = 1'b0;
        data_in   = '0;
        tag_in    = '0;
        set_valid = 1'b0;
        case (state)
            CHECK: begin
                if (hit) begin
                    resp  = 1'b1;
                    rdata = data_out[{req_word, 5'b00000} +: 32];
                end else if (cpu.mem_read) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                arr_index = miss_idx;
                p_read    = 1'b1;
                p_addr    = {miss_tag, miss_idx, 5'b00000};
                if (pmem.pmem_resp) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                arr_index = miss_idx;
                arr_write = 1'b1;
                data_in   = fill_buf;
                tag_in    = miss_tag;
                set_valid = 1'b1;
                state_n   = CHECK;
            end
            default: state_n = CHECK;
        endcase
    end

    assign cpu.mem_resp      = resp;
    assign cpu.mem_rdata     = rdata;
    assign pmem.pmem_read    = p_read;
    assign pmem.pmem_address = p_addr;

    // post_fill marks the CHECK that answers a just-filled miss so it is not also counted as a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CHECK;
            miss_tag   <= '0;
            miss_idx   <= '0;
            fill_buf   <= '0;
            post_fill  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state     <= state_n;
            post_fill <= (state == FILL);
            if (state == CHECK && state_n == FETCH) begin
                miss_tag   <= req_tag;
                miss_idx   <= req_idx;
                miss_count <= miss_count + 1'b1;
            end
            if (state == FETCH && pmem.pmem_resp) begin
                fill_buf <= pmem.pmem_rdata;
            end
            if (state == CHECK && resp && !post_fill) begin
                hit_count <= hit_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_l1_ctrl.sv
// Directed + randomized bench for icache_l1_ctrl against a set/tag cache model.
module tb_icache_l1_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [4:0]   arr_index;
    logic         arr_write;
    logic [255:0] data_in, data_out;
    logic [21:0]  tag_in, tag_out;
    logic [31:0]  hit_count, miss_count;

    icache_cpu_if cpu ();
    icache_pmem_if #(.LINE_W(256)) pm ();

    icache_l1_ctrl #(.LINE_W(256), .TAG_W(22), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu),
        .pmem       (pm),
        .flush      (flush),
        .arr_index  (arr_index),
        .arr_write  (arr_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .tag_in     (tag_in),
        .tag_out    (tag_out),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // external line arrays
    logic [255:0] data_arr [32];
    logic [21:0]  tag_arr  [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                data_arr[i] <= '0;
                tag_arr[i]  <= '0;
            end
        end else if (arr_write) begin
            data_arr[arr_index] <= data_in;
            tag_arr[arr_index]  <= tag_in;
        end
    end
    assign data_out = data_arr[arr_index];
    assign tag_out  = tag_arr[arr_index];

    int errors = 0;
    int checks = 0;
    bit overlap_seen = 0;
    bit offstate_bad = 0;

    // reference cache state
    bit          vm [32];
    logic [21:0] tm [32];
    int          hits_m = 0;
    int          misses_m = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] la;
        la = {a[31:5], 5'b0};
        if (la == 32'h0000_0120 && a[4:2] == 3'd1) return 32'hDEAD_BEEF;
        return (la * 32'h9E37_79B9) ^ {29'b0, a[4:2]} ^ 32'h1357_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(la + 32'(w * 4));
        return l;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) vm[i] = 0;
    endtask

    // runs one fetch to completion, acting as the L2 responder; starts and ends at posedge+1
    task automatic do_read(input logic [31:0] addr, input int d, input int fl_mode,
                           input bit do_swap, input logic [31:0] swap_addr,
                           output int resp_cyc, output logic [31:0] rdata,
                           output logic [31:0] paddr, output int nwr, output logic [4:0] widx);
        int  fcnt = 0;
        int  nfetch = 0;
        bit  flushed = 0;
        resp_cyc = -1; rdata = '0; paddr = 32'hFFFF_FFFF; nwr = 0; widx = 5'h1F;
        cpu.mem_read = 1'b1;
        cpu.mem_address = addr;
        for (int cyc = 0; cyc < 64; cyc++) begin
            pm.pmem_resp = 1'b0;
            pm.pmem_rdata = '0;
            flush = 1'b0;
            if (pm.pmem_read) begin
                if (nfetch == 0 && fcnt == 0) begin
                    paddr = pm.pmem_address;
                    if (do_swap) cpu.mem_address = swap_addr;
                end
                fcnt++;
                if (fcnt == d) begin
                    pm.pmem_resp = 1'b1;
                    pm.pmem_rdata = line_of(pm.pmem_address);
                end
            end else if (fcnt != 0) begin
                fcnt = 0;
                nfetch++;
            end
            if (cyc == 0 && fl_mode == 1) flush = 1'b1;
            if (arr_write && fl_mode == 2 && !flushed) begin
                flush = 1'b1;
                flushed = 1;
            end
            @(negedge clk);
            if (arr_write) begin
                if (nwr == 0) widx = arr_index;
                nwr++;
            end
            if (cpu.mem_resp && pm.pmem_read) overlap_seen = 1;
            if (!cpu.mem_resp && cpu.mem_rdata !== 32'h0) offstate_bad = 1;
            if (!pm.pmem_read && pm.pmem_address !== 32'h0) offstate_bad = 1;
            if (!arr_write && (data_in !== '0 || tag_in !== '0)) offstate_bad = 1;
            if (cpu.mem_resp) begin
                resp_cyc = cyc;
                rdata = cpu.mem_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        if (resp_cyc >= 0) begin
            @(posedge clk); #1;
        end
        pm.pmem_resp = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_read(input string name, input logic [31:0] addr, input int d,
                            input int fl_mode, input bit do_swap, input logic [31:0] swap_addr);
        int          m;
        bit          hit;
        logic [4:0]  idx, sidx;
        logic [21:0] tg, stg;
        logic [31:0] exp_data;
        int          resp_cyc, nwr;
        logic [31:0] rdata, paddr;
        logic [4:0]  widx;
        idx = addr[9:5]; tg = addr[31:10];
        sidx = swap_addr[9:5]; stg = swap_addr[31:10];
        m = 0;
        hit = vm[idx] && (tm[idx] == tg);
        if (fl_mode == 1) model_clear();
        if (!hit) begin
            m = 1;
            if (fl_mode == 2) begin
                model_clear();
                m = 2;
            end
            vm[idx] = 1; tm[idx] = tg;
            if (do_swap && !(vm[sidx] && tm[sidx] == stg)) begin
                m++;
                vm[sidx] = 1; tm[sidx] = stg;
            end
        end
        if (m == 0) hits_m++;
        misses_m += m;
        exp_data = (do_swap && m > 0) ? mem_word(swap_addr) : mem_word(addr);

        do_read(addr, d, fl_mode, do_swap, swap_addr, resp_cyc, rdata, paddr, nwr, widx);

        check({name, ".latency"}, 64'(resp_cyc), 64'(m * (d + 2)));
        check({name, ".rdata"}, 64'(rdata), 64'(exp_data));
        check({name, ".pmem_address"}, 64'(paddr), 64'(m > 0 ? {addr[31:5], 5'b0} : 32'hFFFF_FFFF));
        check({name, ".arr_writes"}, 64'(nwr), 64'(m));
        check({name, ".write_index"}, 64'(widx), 64'(m > 0 ? idx : 5'h1F));
        check({name, ".hit_count"}, 64'(hit_count), 64'(hits_m));
        check({name, ".miss_count"}, 64'(miss_count), 64'(misses_m));
    endtask

    task automatic idle(input bit fl);
        cpu.mem_read = 1'b0;
        flush = fl;
        @(posedge clk); #1;
        flush = 1'b0;
        if (fl) model_clear();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        cpu.mem_read = 1'b0; cpu.mem_address = '0;
        pm.pmem_resp = 1'b0; pm.pmem_rdata = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.pmem_read", 64'(pm.pmem_read), 64'(0));
        check("reset.arr_write", 64'(arr_write), 64'(0));
        check("reset.mem_resp", 64'(cpu.mem_resp), 64'(0));
        check("reset.hit_count", 64'(hit_count), 64'(0));
        check("reset.miss_count", 64'(miss_count), 64'(0));
        @(posedge clk); #1;

        run_read("cold_miss", 32'h0000_0124, 3, 0, 0, '0);
        run_read("hit", 32'h0000_0124, 3, 0, 0, '0);
        run_read("conflict", 32'h0000_0524, 2, 0, 0, '0);
        run_read("conflict_back", 32'h0000_0124, 1, 0, 0, '0);
        idle(1'b1);
        run_read("after_flush", 32'h0000_0124, 2, 0, 0, '0);
        run_read("flush_in_fill", 32'h0000_0924, 2, 2, 0, '0);
        run_read("flush_in_check_hit", 32'h0000_092C, 1, 1, 0, '0);
        run_read("after_check_flush", 32'h0000_0924, 1, 0, 0, '0);
        run_read("addr_change", 32'h0000_0064, 3, 0, 1, 32'h0000_00E8);
        run_read("latched_line", 32'h0000_0068, 1, 0, 0, '0);

        // reset while FETCH is pending
        cpu.mem_read = 1'b1;
        cpu.mem_address = 32'h0003_0040;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_fetch.pre_pmem_read", 64'(pm.pmem_read), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear(); hits_m = 0; misses_m = 0;
        @(negedge clk);
        check("rst_fetch.pmem_read", 64'(pm.pmem_read), 64'(0));
        check("rst_fetch.mem_resp", 64'(cpu.mem_resp), 64'(0));
        check("rst_fetch.hit_count", 64'(hit_count), 64'(0));
        check("rst_fetch.miss_count", 64'(miss_count), 64'(0));
        cpu.mem_read = 1'b0;
        @(posedge clk); #1;
        idle(1'b0);
        run_read("post_rst_miss", 32'h0000_0124, 2, 0, 0, '0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int r;
            a = {20'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 3)),
                 2'b00, 3'($urandom_range(0, 7)), 2'b00};
            r = $urandom_range(0, 9);
            if (r == 0) idle(1'b1);
            run_read("random", a, $urandom_range(1, 4), (r == 1) ? 1 : (r == 2) ? 2 : 0, 0, '0);
            if (r == 3) idle(1'b0);
        end

        check("resp_never_with_pmem_read", 64'(overlap_seen), 64'(0));
        check("off_state_outputs_zero", 64'(offstate_bad), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
